// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequence controller:
// FSM states, {r,g,b} color codes and the sequence-table entry layout.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam logic [2:0] COLOR_OFF     = 3'b000;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;

    // Widest duration the table can hold; the top zero-extends its DUR_W field into it.
    localparam int DUR_MAX_W = 16;

    typedef struct packed {
        logic [2:0]           color;
        logic [DUR_MAX_W-1:0] dur;
    } entry_t;

    // A stored duration of zero still occupies one tick.
    function automatic logic [DUR_MAX_W-1:0] eff_dur(input logic [DUR_MAX_W-1:0] d);
        if (d == '0) begin
            return {{(DUR_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/led_sequence_ctrl_prescaler.sv
// Free-running divider producing one tick every DIV enabled cycles.
// Holds while en is low; clr restarts the count from zero.
module tick_prescaler #(
    parameter int DIV = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and tick strobe.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequence_ctrl.sv
// Plays a programmable table of {color, duration} steps on an RGB LED,
// with start/stop/pause control and a wrap pulse at the end of each pass.
module led_sequence_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 12000,
    parameter int MAX_STEPS = 8,
    parameter int DUR_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [2:0]       cfg_color,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [3:0]       seq_len,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic             busy,
    output logic [2:0]       step_idx,
    output logic             wrap
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_STEPS);

    entry_t               table_q [MAX_STEPS];
    state_e               state_q;
    logic [2:0]           rgb_q;
    logic                 busy_q;
    logic [2:0]           step_q;
    logic                 wrap_q;
    logic [3:0]           len_q;
    logic [DUR_MAX_W-1:0] dur_cnt_q;

    logic                 tick_s;
    logic                 start_ok_s;
    logic                 presc_en_s;
    logic                 presc_clr_s;
    logic                 last_step_s;
    logic [2:0]           step_d;
    entry_t               next_entry_s;
    entry_t               first_entry_s;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en_s),
        .clr  (presc_clr_s),
        .tick (tick_s)
    );

    // Command qualification and next-step selection.
    always_comb begin
        start_ok_s    = start && (seq_len != 4'd0) && (seq_len <= MAX_LEN);
        last_step_s   = ({1'b0, step_q} == (len_q - 4'd1));
        if (last_step_s) begin
            step_d = 3'd0;
        end else begin
            step_d = step_q + 3'd1;
        end
        next_entry_s  = table_q[step_d];
        first_entry_s = table_q[0];
        presc_en_s    = (state_q == ST_RUN);
        presc_clr_s   = stop || start_ok_s;
    end

    // Sequence table; a write lands after this edge, so the running step keeps its loaded copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < MAX_LEN)) begin
            table_q[cfg_addr] <= '{color: cfg_color, dur: DUR_MAX_W'(cfg_dur)};
        end
    end

    // Control FSM with registered LED, busy, index and wrap outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rgb_q     <= COLOR_OFF;
            busy_q    <= 1'b0;
            step_q    <= 3'd0;
            wrap_q    <= 1'b0;
            len_q     <= 4'd0;
            dur_cnt_q <= '0;
        end else if (stop) begin
            state_q   <= ST_IDLE;
            rgb_q     <= COLOR_OFF;
            busy_q    <= 1'b0;
            step_q    <= 3'd0;
            wrap_q    <= 1'b0;
            dur_cnt_q <= '0;
        end else if (start_ok_s) begin
            state_q   <= ST_RUN;
            len_q     <= seq_len;
            step_q    <= 3'd0;
            dur_cnt_q <= eff_dur(first_entry_s.dur);
            rgb_q     <= first_entry_s.color;
            busy_q    <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wrap_q <= 1'b0;
                end
                ST_RUN: begin
                    wrap_q <= 1'b0;
                    if (tick_s) begin
                        // Last tick of the step: load the following entry fresh from the table.
                        if (dur_cnt_q <= {{(DUR_MAX_W-1){1'b0}}, 1'b1}) begin
                            step_q    <= step_d;
                            dur_cnt_q <= eff_dur(next_entry_s.dur);
                            rgb_q     <= next_entry_s.color;
                            wrap_q    <= last_step_s;
                        end else begin
                            dur_cnt_q <= dur_cnt_q - {{(DUR_MAX_W-1){1'b0}}, 1'b1};
                        end
                    end
                    if (pause) begin
                        state_q <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    wrap_q <= 1'b0;
                    if (!pause) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rgb_q     <= COLOR_OFF;
                    busy_q    <= 1'b0;
                    step_q    <= 3'd0;
                    wrap_q    <= 1'b0;
                    dur_cnt_q <= '0;
                end
            endcase
        end
    end

    assign red      = rgb_q[2];
    assign green    = rgb_q[1];
    assign blue     = rgb_q[0];
    assign busy     = busy_q;
    assign step_idx = step_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Scoreboard bench for led_sequence_ctrl with TICK_DIV=4: expected
// {r,g,b,busy,step_idx,wrap} per cycle is queued, then popped and compared.
module tb_led_sequence_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int MAX_STEPS = 8;
    localparam int DUR_W     = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [2:0]       cfg_color;
    logic [DUR_W-1:0] cfg_dur;
    logic [3:0]       seq_len;
    logic             start;
    logic             stop;
    logic             pause;
    logic             red, green, blue, busy, wrap;
    logic [2:0]       step_idx;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       sb [$];
    logic [2:0]       pal [6];

    led_sequence_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .MAX_STEPS (MAX_STEPS),
        .DUR_W     (DUR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_color (cfg_color),
        .cfg_dur   (cfg_dur),
        .seq_len   (seq_len),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .busy      (busy),
        .step_idx  (step_idx),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pack_exp(input logic [2:0] rgb, input logic b,
                                            input logic [2:0] idx, input logic w);
        return {rgb, b, idx, w};
    endfunction

    task automatic write_entry(input logic [2:0] a, input logic [2:0] c, input logic [DUR_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_color = c; cfg_dur = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic stop_seq();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 6; i++) begin
            write_entry(3'(i), pal[i], 10'd2);
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs, exp_v;
        rst = 1'b1;
        sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
        sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
        for (int k = 1; k <= 2; k++) begin
            cyc();
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] obs, exp_v;
        for (int k = 1; k <= 50; k++) begin
            sb.push_back(pack_exp(pal[((k-1)/8)%6], 1'b1, 3'(((k-1)/8)%6), k == 49));
        end
        seq_len = 4'd6;
        start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            cyc();
            start = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sequence k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        stop_seq();
    endtask

    task automatic test_pause();
        logic [7:0] obs, exp_v;
        int idx;
        for (int k = 1; k <= 27; k++) begin
            idx = (k <= 18) ? 0 : ((k <= 26) ? 1 : 2);
            sb.push_back(pack_exp(pal[idx], 1'b1, 3'(idx), 1'b0));
        end
        seq_len = 4'd6;
        start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            cyc();
            start = 1'b0;
            if (k == 3)  pause = 1'b1;
            if (k == 13) pause = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pause k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_stop_start();
        logic [7:0] obs, exp_v;
        sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
        sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
        seq_len = 4'd6;
        stop = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            stop = 1'b0;
            start = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stop_start k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_invalid_len();
        logic [7:0] obs, exp_v;
        logic [3:0] bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
            seq_len = bad[i];
            start = 1'b1;
            cyc();
            start = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL invalid_len len=%0d got=%b want=%b", bad[i], obs, exp_v);
            end
        end
        write_entry(3'd0, 3'b011, 10'd0);
        for (int k = 1; k <= 13; k++) begin
            sb.push_back(pack_exp(3'b011, 1'b1, 3'd0, (k == 5) || (k == 9) || (k == 13)));
        end
        seq_len = 4'd1;
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            start = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL single_step k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        stop_seq();
    endtask

    task automatic test_live_write();
        logic [7:0] obs, exp_v;
        logic [2:0] c;
        int idx;
        write_entry(3'd0, pal[0], 10'd2);
        for (int k = 1; k <= 29; k++) begin
            idx = (k <= 8) ? 0 : (k <= 16) ? 1 : (k <= 20) ? 0 : (k <= 28) ? 1 : 0;
            c = (idx == 1) ? pal[1] : ((k <= 8) ? pal[0] : 3'b001);
            sb.push_back(pack_exp(c, 1'b1, 3'(idx), (k == 17) || (k == 29)));
        end
        seq_len = 4'd2;
        start = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            cyc();
            start = 1'b0;
            if (k == 2) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_color = 3'b001; cfg_dur = 10'd1;
            end
            if (k == 3) cfg_we = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL live_write k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        stop_seq();
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs, exp_v;
        write_entry(3'd0, pal[0], 10'd2);
        for (int k = 1; k <= 20; k++) begin
            if (k == 20) sb.push_back(pack_exp(3'b000, 1'b0, 3'd0, 1'b0));
            else         sb.push_back(pack_exp(pal[(k-1)/8], 1'b1, 3'((k-1)/8), 1'b0));
        end
        seq_len = 4'd6;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            start = 1'b0;
            if (k == 19) rst = 1'b1;
            if (k == 20) rst = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            sb.push_back(pack_exp(3'b000, 1'b1, 3'((k-1)/4), 1'b0));
        end
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            start = 1'b0;
            obs = {red, green, blue, busy, step_idx, wrap};
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL cleared_table k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        pal[0] = 3'b100; pal[1] = 3'b110; pal[2] = 3'b010;
        pal[3] = 3'b011; pal[4] = 3'b001; pal[5] = 3'b101;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_color = 3'd0; cfg_dur = '0;
        seq_len = 4'd0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        test_reset();
        load_table();
        test_sequence();
        test_pause();
        test_stop_start();
        test_invalid_len();
        test_live_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequence_ctrl.md
LED_SEQUENCE_CTRL -- requirements
Module: led_sequence_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TICK_DIV  12000  clk cycles per duration tick (1 ms at 12 MHz)
  MAX_STEPS  8  sequence table depth
  DUR_W  10  step-duration width, in ticks
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single system clock, rising edge
  rst  in  1  reset, synchronous, active-high
  cfg_we  in  1  table write strobe
  cfg_addr  in  3  table entry index
  cfg_color  in  3  entry color {r,g,b}
  cfg_dur  in  DUR_W  entry duration in ticks
  seq_len  in  4  number of active steps, sampled on start
  start  in  1  pulse: begin/restart sequence at entry 0
  stop  in  1  pulse: abort to idle
  pause  in  1  level: freeze while high
  red, green, blue  out  1 each  registered LED drive
  busy  out  1  high in RUN or PAUSED
  step_idx  out  3  current entry index
  wrap  out  1  one-cycle pulse on wrap from last step to entry 0
REQ-003 There SHALL be one clock (clk); reset SHALL be synchronous and active-high on rst.

Function
REQ-004 FSM states SHALL be IDLE, RUN, PAUSED.
REQ-005 Command priority within a cycle SHALL be rst > stop > start > pause.
REQ-006 IDLE->RUN on start only if 1 <= seq_len <= MAX_STEPS; otherwise start SHALL be ignored.
REQ-007 On an accepted start, the block SHALL latch seq_len, set step_idx=0, clear the prescaler and load the duration counter from entry 0.
REQ-008 start in RUN or PAUSED SHALL restart as in REQ-007 and SHALL end in RUN regardless of pause.
REQ-009 stop in any state SHALL enter IDLE next cycle with all outputs 0.
REQ-010 RUN->PAUSED when pause is high; PAUSED->RUN when pause is low; in PAUSED the prescaler, duration counter and outputs SHALL hold.
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 in RUN only and SHALL emit a tick when at TICK_DIV-1.
REQ-012 A stored duration of 0 SHALL be treated as 1.
REQ-013 Step k SHALL be displayed for exactly max(dur_k,1)*TICK_DIV RUN cycles.
REQ-014 On expiry, step_idx SHALL advance by 1 and wrap to 0 after seq_len-1; wrap SHALL pulse in the same cycle as the 0 load.
REQ-015 seq_len=1 SHALL re-show entry 0 and pulse wrap every period.
REQ-016 red/green/blue SHALL be registered and SHALL reflect the current entry starting the cycle after the step is entered (start at cycle N -> entry 0 color at N+1).
REQ-017 A table write SHALL take effect the cycle after cfg_we and SHALL apply to an entry only at its next load; a write to the running entry SHALL NOT alter its loaded duration or its displayed color.
REQ-018 Table writes SHALL be accepted in every state; cfg_addr >= MAX_STEPS SHALL be ignored.

Reset
REQ-019 On rst: state IDLE; red=green=blue=0; busy=0; step_idx=0; wrap=0; counters 0; latched length 0; table entries reset to color 0, duration 0.
REQ-020 rst asserted mid-sequence SHALL take effect at the next clk edge, overriding every other input.

Structure
REQ-021 Package led_seq_pkg SHALL hold the state enum, the color constants (RED=100, YELLOW=110, GREEN=010, CYAN=011, BLUE=001, MAGENTA=101, OFF=000 in {r,g,b} order) and the table-entry struct {color, dur}.
REQ-022 The prescaler SHALL be the sub-module tick_prescaler (params DIV; ports clk, rst, en, clr, tick).

Verification (TICK_DIV=4)
REQ-023 Load entries 0..5 = RED..MAGENTA with dur=2, seq_len=6, start -> each color held 8 cycles in order; wrap pulse after MAGENTA; RED reappears at cycle 49 after start.
REQ-024 Hold pause high for 10 cycles mid-step -> outputs frozen for 10 cycles; remaining step time unchanged after release.
REQ-025 Assert stop and start in the same cycle during RUN -> IDLE, outputs 000, busy=0.
REQ-026 Issue start with seq_len=0, then with seq_len=9 -> remains IDLE, busy=0; seq_len=1 with dur=0 -> wrap every 4 cycles.
REQ-027 Write entry 0 to BLUE while entry 0 is displaying RED -> RED held to its full duration; BLUE shown on the next pass.
REQ-028 Assert rst at the third cycle of step 2 -> all outputs 0 the next cycle; a subsequent start begins at entry 0 with table cleared (color 000).
